mdu_iter: RTL and testbench

- Iterative multiply/divide unit for the multi-cycle CPU; sits directly downstream of the register file read ports.
- Consumes the two register operands and computes MULT/MULTU/DIV/DIVU into architectural HI/LO registers.
- HI/LO outputs feed back toward the register-file write-data mux for MFHI/MFLO.
- MTHI/MTLO write paths are included.

---
 rtl/mdu_iter_if.sv | 26 ++
 rtl/mdu_iter.sv | 171 +++++++++++++++++
 tb/tb_mdu_iter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// Handshake and HI/LO bus between the register-file read side and the iterative multiply/divide unit.
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO write paths.
// Sign-magnitude operation: magnitudes are iterated for 32 cycles, signs are applied in FIX.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic        clk,
    input  logic        rst,
    mdu_iter_if.slave   bus
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic [1:0]         r_op;
    logic               r_sa;
    logic               r_sb;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_busy;
    logic               w_accept;
    logic               w_calc;
    logic               w_fix;
    logic               w_mt_ok;

    logic               w_signed_in;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_div_next;

    logic               w_is_div;
    logic               w_signed;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fix_hi;
    logic [WIDTH-1:0]   w_fix_lo;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all registers update from pre-edge values.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so no path leaves w_next unassigned and a latch is never inferred.
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start)                 w_next = S_CALC;
            S_CALC:  if (r_cnt == CW'(ITER - 1))    w_next = S_FIX;
            S_FIX:                                  w_next = S_IDLE;
            default:                                w_next = S_IDLE;
        endcase
    end

    // Output/control decode.
    always_comb begin
        w_busy   = 1'b0;
        w_accept = 1'b0;
        w_calc   = 1'b0;
        w_fix    = 1'b0;
        w_mt_ok  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_accept = bus.start;
                w_mt_ok  = ~bus.start;
            end
            S_CALC: begin
                w_busy = 1'b1;
                w_calc = 1'b1;
            end
            S_FIX: begin
                w_busy = 1'b1;
                w_fix  = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand magnitudes at load; op[0]=0 selects the signed variants.
    assign w_signed_in = ~bus.op[0];
    assign w_a_mag = (w_signed_in && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_b_mag = (w_signed_in && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // Multiply: upper half accumulates, lower half shifts the multiplier out as the product shifts in.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts the dividend out and quotient in.
    assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff     = w_trial - {1'b0, r_b};
    assign w_div_next = w_diff[WIDTH] ? {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    // Sign fix-up; a zero divisor forces an all-ones quotient and the remainder reproduces a.
    assign w_is_div = r_op[1];
    assign w_signed = ~r_op[0];
    assign w_prod   = (w_signed && (r_sa ^ r_sb)) ? -r_acc : r_acc;
    assign w_quo    = r_acc[WIDTH-1:0];
    assign w_rem    = r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fix_lo = w_prod[WIDTH-1:0];
        if (w_is_div) begin
            w_fix_hi = (w_signed && r_sa) ? -w_rem : w_rem;
            if (r_b == '0)
                w_fix_lo = '1;
            else
                w_fix_lo = (w_signed && (r_sa ^ r_sb)) ? -w_quo : w_quo;
        end
    end

    // Datapath and architectural registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fix;
            if (w_accept) begin
                r_cnt <= '0;
                r_acc <= {{WIDTH{1'b0}}, w_a_mag};
                r_b   <= w_b_mag;
                r_op  <= bus.op;
                r_sa  <= w_signed_in & bus.a[WIDTH-1];
                r_sb  <= w_signed_in & bus.b[WIDTH-1];
            end else if (w_calc) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= w_is_div ? w_div_next : w_mul_next;
            end
            if (w_fix) begin
                r_hi <= w_fix_hi;
                r_lo <= w_fix_lo;
            end else if (w_mt_ok) begin
                if (bus.hi_we) r_hi <= bus.wd;
                if (bus.lo_we) r_lo <= bus.wd;
            end
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus randomized ops against an arithmetic reference.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mdu_iter_if #(.WIDTH(32)) bus ();

    mdu_iter #(.WIDTH(32), .ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint      sa, sb, q, r;
        logic [63:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: begin t = sa * sb; hi = t[63:32]; lo = t[31:0]; end
            2'b01: begin t = 64'(a) * 64'(b); hi = t[63:32]; lo = t[31:0]; end
            2'b10: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin
                    q = sa / sb; r = sa % sb;
                    t = q; lo = t[31:0];
                    t = r; hi = t[31:0];
                end
            end
            default: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin hi = a % b; lo = a / b; end
            end
        endcase
    endtask

    task automatic quiet();
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
    endtask

    // Called #1 after an edge; the start edge is the next posedge (E0).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb, input bit we_at_start);
        logic [31:0] e_hi, e_lo;
        int n;
        bit got_done;
        model(op, a, b, e_hi, e_lo);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.hi_we = we_at_start;
        bus.lo_we = we_at_start;
        bus.wd    = 32'hA5A5A5A5;
        n = 0;
        got_done = 1'b0;
        while (n < 40 && !got_done) begin
            @(posedge clk); #1;
            n++;
            got_done = bus.done;
            if (!got_done) begin
                check("busy_during_op", 64'(bus.busy), 64'd1);
                check("hi_held", 64'(bus.hi), 64'(m_hi));
                check("lo_held", 64'(bus.lo), 64'(m_lo));
            end
            if (disturb && n <= 32) begin
                bus.start = 1'b1;
                bus.op    = 2'($urandom_range(0, 3));
                bus.a     = $urandom;
                bus.b     = $urandom;
                bus.hi_we = 1'($urandom_range(0, 1));
                bus.lo_we = 1'($urandom_range(0, 1));
                bus.wd    = $urandom;
            end else begin
                quiet();
            end
        end
        check("latency_edges", 64'(n), 64'd34);
        check("done_pulse", 64'(bus.done), 64'd1);
        check("busy_at_done", 64'(bus.busy), 64'd0);
        check("result_hi", 64'(bus.hi), 64'(e_hi));
        check("result_lo", 64'(bus.lo), 64'(e_lo));
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    task automatic mt_write(input bit hwe, input bit lwe, input logic [31:0] data);
        bus.start = 1'b0;
        bus.hi_we = hwe;
        bus.lo_we = lwe;
        bus.wd    = data;
        @(posedge clk); #1;
        quiet();
        if (hwe) m_hi = data;
        if (lwe) m_lo = data;
        check("mt_hi", 64'(bus.hi), 64'(m_hi));
        check("mt_lo", 64'(bus.lo), 64'(m_lo));
        check("mt_no_done", 64'(bus.done), 64'd0);
    endtask

    initial begin
        int   done_seen;
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;

        quiet();
        bus.op = '0;
        bus.a  = '0;
        bus.b  = '0;
        bus.wd = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);

        // Directed corner cases, issued back to back so each start lands in the previous done cycle.
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(2'b00, 32'hFFFFFFF9, 32'd3,        1'b0, 1'b0);
        run_op(2'b00, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2,        1'b0, 1'b0);
        run_op(2'b11, 32'd100,      32'd7,        1'b0, 1'b0);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        run_op(2'b11, 32'h00001234, 32'd0,        1'b0, 1'b0);
        run_op(2'b10, 32'hFFFFFF00, 32'd0,        1'b0, 1'b0);

        // start spam, operand toggling and MTHI/MTLO attempts while busy.
        run_op(2'b00, 32'h00012345, 32'hFFFF0001, 1'b1, 1'b0);

        mt_write(1'b1, 1'b0, 32'hA5A5A5A5);
        mt_write(1'b1, 1'b1, 32'h5A5A0F0F);

        // hi_we/lo_we together with start: start wins, HI/LO unchanged until done.
        run_op(2'b11, 32'hDEADBEEF, 32'h00000010, 1'b0, 1'b1);

        // Randomized ops with occasional corner operands.
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = '0;
                1: begin r_a = 32'h80000000; r_b = 32'hFFFFFFFF; end
                2: begin r_a = 32'($urandom_range(0, 200)); r_b = 32'($urandom_range(1, 15)); end
                3: r_b = 32'(-$signed(32'($urandom_range(1, 9))));
                default: ;
            endcase
            run_op(r_op, r_a, r_b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset mid-CALC abandons the op: HI/LO cleared, no done pulse ever.
        mt_write(1'b1, 1'b0, 32'h11);
        mt_write(1'b0, 1'b1, 32'h22);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'h00000123;
        bus.b     = 32'h00000456;
        @(posedge clk); #1;
        quiet();
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hi", 64'(bus.hi), 64'd0);
        check("abort_lo", 64'(bus.lo), 64'd0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) done_seen++;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_hi_held", 64'(bus.hi), 64'd0);

        // Unit still works after the abort.
        run_op(2'b00, 32'hFFFFFFF9, 32'd3, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
